// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared constants and types for the forwarding scoreboard.
//   FSEL_REGFILE      forward select value meaning "take operand from regfile"
//   REG_AW_DEFAULT    default register address width
//   ZERO_REG_DEFAULT  default zero register (XZR), never forwarded
//   stageFlags_t      per-stage control flags tracked after EX
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int FSEL_REGFILE     = 0;
    localparam int REG_AW_DEFAULT   = 5;
    localparam int ZERO_REG_DEFAULT = 31;

    typedef struct packed {
        logic valid;
        logic regwrite;
    } stageFlags_t;

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Priority compare of one EX source operand against DEPTH tracked stages.
// The youngest (lowest-numbered) live writer whose rd matches wins.
// Ports:
//   exValid     in  EX entry holds a real instruction
//   rsUsed      in  this source operand is actually read
//   rs          in  source register address
//   stageLive   in  per stage: valid, writes rd, rd is not the zero register
//   stageRd     in  per stage destination, stage k at [(k-1)*REG_AW +: REG_AW]
//   sel         out 0 = regfile, k = forward from stage k
// -----------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter int  REG_AW = REG_AW_DEFAULT,
    localparam int FSEL_W = $clog2(DEPTH + 1)
) (
    input  logic                      exValid,
    input  logic                      rsUsed,
    input  logic [REG_AW-1:0]         rs,
    input  logic [DEPTH-1:0]          stageLive,
    input  logic [DEPTH*REG_AW-1:0]   stageRd,
    output logic [FSEL_W-1:0]         sel
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel = FSEL_W'(FSEL_REGFILE);
        if (exValid && rsUsed) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (stageLive[k-1] && (stageRd[(k-1)*REG_AW +: REG_AW] == rs)) begin
                    sel = FSEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// forwarding_scoreboard
// Tracks in-flight destination registers across DEPTH post-EX stages, drives
// one forward select per EX read port and the load-use stall for ID.
// Optional feature macro: FWD_STATS_EN (adds stall / forward event counters).
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   hold                 freeze all state this edge
//   flush                squash the instruction leaving ID
//   id_valid, id_rd, id_regwrite, id_memread, id_rs, id_rs_used
//                        ID-stage instruction fields (port p at [p*REG_AW +: REG_AW])
//   fwd_sel              per EX operand select, port p at [p*FSEL_W +: FSEL_W]
//   load_stall           hold PC and IF/ID, insert a bubble into EX
//   stat_stall_cnt, stat_fwd_cnt   (FWD_STATS_EN only) saturating counters
// -----------------------------------------------------------------------------
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter int  NUM_RD_PORTS = 2,
    parameter int  REG_AW       = REG_AW_DEFAULT,
    parameter int  ZERO_REG     = ZERO_REG_DEFAULT,
    parameter int  DEPTH        = 2,
    localparam int FSEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hold,
    input  logic                           flush,
    input  logic                           id_valid,
    input  logic [REG_AW-1:0]              id_rd,
    input  logic                           id_regwrite,
    input  logic                           id_memread,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs,
    input  logic [NUM_RD_PORTS-1:0]        id_rs_used,
    output logic [NUM_RD_PORTS*FSEL_W-1:0] fwd_sel,
    output logic                           load_stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                    stat_stall_cnt,
    output logic [31:0]                    stat_fwd_cnt
`endif
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

    // EX entry
    logic                           exValidReg;
    logic [REG_AW-1:0]              exRdReg;
    logic                           exRegwriteReg;
    logic                           exMemreadReg;
    logic [NUM_RD_PORTS*REG_AW-1:0] exRsReg;
    logic [NUM_RD_PORTS-1:0]        exRsUsedReg;

    // Post-EX stages, stage k held at index k-1
    stageFlags_t [DEPTH-1:0]        stgFlagsReg;
    logic [DEPTH*REG_AW-1:0]        stgRdReg;
    // Only stage 1 can ever be observed as a load (load-use hazard invariant),
    // so memread is kept for that stage alone.
    logic                           stg1MemreadReg;

    logic [DEPTH-1:0]               stgLive;
    logic [NUM_RD_PORTS-1:0]        idHit;
    logic [NUM_RD_PORTS-1:0]        stage1Hit;
    logic                           exBubble;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
        assign stgLive[gi] = stgFlagsReg[gi].valid & stgFlagsReg[gi].regwrite
                           & (stgRdReg[gi*REG_AW +: REG_AW] != ZERO_ADDR);
    end

    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
        fwd_match #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW)
        ) u_match (
            .exValid   (exValidReg),
            .rsUsed    (exRsUsedReg[gi]),
            .rs        (exRsReg[gi*REG_AW +: REG_AW]),
            .stageLive (stgLive),
            .stageRd   (stgRdReg),
            .sel       (fwd_sel[gi*FSEL_W +: FSEL_W])
        );

        assign idHit[gi]     = id_rs_used[gi] & (id_rs[gi*REG_AW +: REG_AW] == exRdReg);
        assign stage1Hit[gi] = (fwd_sel[gi*FSEL_W +: FSEL_W] == FSEL_W'(1));
    end

    // A zero-register load never stalls; since exRdReg != ZERO_ADDR is required,
    // an ID source of ZERO_REG cannot match either.
    assign load_stall = id_valid & exValidReg & exMemreadReg & exRegwriteReg
                      & (exRdReg != ZERO_ADDR) & (|idHit);

    assign exBubble = load_stall | flush | ~id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exValidReg     <= 1'b0;
            exRdReg        <= '0;
            exRegwriteReg  <= 1'b0;
            exMemreadReg   <= 1'b0;
            exRsReg        <= '0;
            exRsUsedReg    <= '0;
            stgFlagsReg    <= '0;
            stgRdReg       <= '0;
            stg1MemreadReg <= 1'b0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                stgFlagsReg[k]                 <= stgFlagsReg[k-1];
                stgRdReg[k*REG_AW +: REG_AW]   <= stgRdReg[(k-1)*REG_AW +: REG_AW];
            end
            stgFlagsReg[0]          <= '{valid: exValidReg, regwrite: exRegwriteReg};
            stgRdReg[0 +: REG_AW]   <= exRdReg;
            stg1MemreadReg          <= exMemreadReg;

            if (exBubble) begin
                exValidReg    <= 1'b0;
                exRdReg       <= '0;
                exRegwriteReg <= 1'b0;
                exMemreadReg  <= 1'b0;
                exRsReg       <= '0;
                exRsUsedReg   <= '0;
            end else begin
                exValidReg    <= 1'b1;
                exRdReg       <= id_rd;
                exRegwriteReg <= id_regwrite;
                exMemreadReg  <= id_memread;
                exRsReg       <= id_rs;
                exRsUsedReg   <= id_rs_used;
            end
        end
    end

    // A load sitting in stage 1 must never be the forwarding source: the
    // load-use stall always separates it from its consumer by one bubble.
    noLoadFwdAtStage1: assert property (@(posedge clk) disable iff (reset)
        !(stg1MemreadReg && (|stage1Hit)));

`ifdef FWD_STATS_EN
    logic [31:0] stallCntReg;
    logic [31:0] fwdCntReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCntReg <= '0;
            fwdCntReg   <= '0;
        end else if (!hold) begin
            if (load_stall && (stallCntReg != 32'hFFFF_FFFF)) begin
                stallCntReg <= stallCntReg + 32'd1;
            end
            if ((|fwd_sel) && (fwdCntReg != 32'hFFFF_FFFF)) begin
                fwdCntReg <= fwdCntReg + 32'd1;
            end
        end
    end

    assign stat_stall_cnt = stallCntReg;
    assign stat_fwd_cnt   = fwdCntReg;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forwarding_scoreboard
// Directed stimulus for forwarding_scoreboard (default parameters) against an
// instruction-history model of the pipeline, plus literal expectations.
// Optional macro: FWD_STATS_EN (also checks the event counters).
// -----------------------------------------------------------------------------
module tb_forwarding_scoreboard;

    localparam int AW    = 5;
    localparam int NP    = 2;
    localparam int DEPTH = 2;
    localparam int FW    = 2;
    localparam int ZR    = 31;

    logic            clk        = 1'b0;
    logic            reset      = 1'b0;
    logic            hold       = 1'b0;
    logic            flush      = 1'b0;
    logic            idValid    = 1'b0;
    logic [AW-1:0]   idRd       = '0;
    logic            idRegwrite = 1'b0;
    logic            idMemread  = 1'b0;
    logic [NP*AW-1:0] idRs      = '0;
    logic [NP-1:0]   idRsUsed   = '0;
    logic [NP*FW-1:0] fwdSel;
    logic            loadStall;
`ifdef FWD_STATS_EN
    logic [31:0]     statStallCnt;
    logic [31:0]     statFwdCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (idValid),
        .id_rd       (idRd),
        .id_regwrite (idRegwrite),
        .id_memread  (idMemread),
        .id_rs       (idRs),
        .id_rs_used  (idRsUsed),
        .fwd_sel     (fwdSel),
        .load_stall  (loadStall)
`ifdef FWD_STATS_EN
        ,
        .stat_stall_cnt (statStallCnt),
        .stat_fwd_cnt   (statFwdCnt)
`endif
    );

    // ---------------- model: history of instructions past ID ----------------
    typedef struct packed {
        logic              valid;
        logic [AW-1:0]     rd;
        logic              rw;
        logic              mr;
        logic [NP-1:0][AW-1:0] rs;
        logic [NP-1:0]     used;
    } instT;

    instT        mEx;
    instT        mStg [1:DEPTH];
    logic [31:0] mStallCnt;
    logic [31:0] mFwdCnt;

    function automatic int expSel(input int p);
        if (!mEx.valid || !mEx.used[p]) return 0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (mStg[k].valid && mStg[k].rw && mStg[k].rd != ZR && mStg[k].rd == mEx.rs[p])
                return k;
        end
        return 0;
    endfunction

    function automatic logic [NP*FW-1:0] expFwd();
        logic [NP*FW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*FW +: FW] = FW'(expSel(p));
        return v;
    endfunction

    function automatic logic expStall();
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NP; p++)
            if (idRsUsed[p] && idRs[p*AW +: AW] == mEx.rd) hit = 1'b1;
        return idValid && mEx.valid && mEx.mr && mEx.rw && (mEx.rd != ZR) && hit;
    endfunction

    function automatic instT idAsInst();
        instT t;
        t.valid = 1'b1;
        t.rd    = idRd;
        t.rw    = idRegwrite;
        t.mr    = idMemread;
        for (int p = 0; p < NP; p++) t.rs[p] = idRs[p*AW +: AW];
        t.used  = idRsUsed;
        return t;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mEx       <= '0;
            for (int k = 1; k <= DEPTH; k++) mStg[k] <= '0;
            mStallCnt <= '0;
            mFwdCnt   <= '0;
        end else if (!hold) begin
            if (expStall() && mStallCnt != 32'hFFFF_FFFF) mStallCnt <= mStallCnt + 1;
            if (expFwd() != '0 && mFwdCnt != 32'hFFFF_FFFF) mFwdCnt <= mFwdCnt + 1;
            for (int k = DEPTH; k >= 2; k--) mStg[k] <= mStg[k-1];
            mStg[1] <= mEx;
            mEx     <= (expStall() || flush || !idValid) ? '0 : idAsInst();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++)
                check($sformatf("model fwd_sel[%0d]", p), 32'(fwdSel[p*FW +: FW]), 32'(expSel(p)));
            check("model load_stall", 32'(loadStall), 32'(expStall()));
`ifdef FWD_STATS_EN
            check("model stat_stall_cnt", statStallCnt, mStallCnt);
            check("model stat_fwd_cnt", statFwdCnt, mFwdCnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic setId(input logic v, input int rd, input logic rw, input logic mr,
                         input int rs0, input int rs1, input logic [1:0] used);
        idValid    = v;
        idRd       = AW'(rd);
        idRegwrite = rw;
        idMemread  = mr;
        idRs       = {AW'(rs1), AW'(rs0)};
        idRsUsed   = used;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("tb_forwarding_scoreboard: start");
        #1 reset = 1'b1;
        tick();
        tick();
        check("reset fwd_sel", 32'(fwdSel), 32'h0);
        check("reset load_stall", 32'(loadStall), 32'h0);
        reset = 1'b0;
        tick();

        // 1: ADD X1 ; ADD X2,X1,X1
        setId(1, 1, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 2, 1, 0, 1, 1, 2'b11); tick();
        check("s1 both ports fwd 1", 32'(fwdSel), 32'h5);
        check("s1 no stall", 32'(loadStall), 32'h0);

        // 2: X3 in stage1 and stage2 -> youngest; then X4 in stage1 -> stage2
        setId(1, 3, 1, 0, 0, 0, 2'b00); tick(); tick();
        setId(1, 9, 1, 0, 3, 0, 2'b01); tick();
        check("s2 youngest wins", 32'(fwdSel), 32'h1);
        setId(1, 3, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 4, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 9, 1, 0, 3, 0, 2'b01); tick();
        check("s2 fwd from stage2", 32'(fwdSel), 32'h2);

        // 3: LDUR X5 then reader of X5
        setId(1, 5, 1, 1, 0, 0, 2'b00); tick();
        setId(1, 6, 1, 0, 5, 0, 2'b01); #1;
        check("s3 stall", 32'(loadStall), 32'h1);
        tick();
        check("s3 bubble no stall", 32'(loadStall), 32'h0);
        check("s3 bubble no fwd", 32'(fwdSel), 32'h0);
        tick();
        check("s3 fwd from load at 2", 32'(fwdSel), 32'h2);

        // 4: zero register and non-writing instructions
        setId(1, 31, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 7, 1, 0, 31, 31, 2'b11); tick();
        check("s4 xzr never fwd", 32'(fwdSel), 32'h0);
        setId(1, 31, 1, 1, 0, 0, 2'b00); tick();
        setId(1, 7, 1, 0, 31, 0, 2'b01); #1;
        check("s4 xzr load no stall", 32'(loadStall), 32'h0);
        tick();
        setId(1, 8, 0, 0, 0, 0, 2'b00); tick();
        setId(1, 9, 1, 0, 8, 8, 2'b11); tick();
        check("s4 regwrite0 no fwd", 32'(fwdSel), 32'h0);

        // 5: hold mid-hazard, then flush
        setId(1, 12, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 5, 1, 1, 12, 0, 2'b01); tick();
        check("s5 load reads fwd", 32'(fwdSel), 32'h1);
        setId(1, 6, 1, 0, 0, 5, 2'b10); #1;
        check("s5 stall before hold", 32'(loadStall), 32'h1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s5 hold%0d fwd", i), 32'(fwdSel), 32'h1);
            check($sformatf("s5 hold%0d stall", i), 32'(loadStall), 32'h1);
        end
        hold = 1'b0;
        tick();
        check("s5 post-hold bubble", 32'(loadStall), 32'h0);
        tick();
        check("s5 port1 fwd 2", 32'(fwdSel), 32'h8);
        setId(1, 8, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 9, 1, 0, 8, 0, 2'b01); flush = 1'b1; tick();
        flush = 1'b0;
        check("s5 flush no fwd", 32'(fwdSel), 32'h0);

        // 6: async reset with live entries
        setId(1, 10, 1, 0, 0, 0, 2'b00); tick();
        setId(1, 11, 1, 1, 10, 0, 2'b01); tick();
        check("s6 live fwd", 32'(fwdSel), 32'h1);
        setId(1, 13, 1, 0, 11, 0, 2'b01); #1;
        check("s6 live stall", 32'(loadStall), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("s6 async fwd cleared", 32'(fwdSel), 32'h0);
        check("s6 async stall cleared", 32'(loadStall), 32'h0);
`ifdef FWD_STATS_EN
        check("s6 stall cnt cleared", statStallCnt, 32'h0);
        check("s6 fwd cnt cleared", statFwdCnt, 32'h0);
`endif
        #3 reset = 1'b0;
        tick();
        setId(1, 14, 1, 0, 13, 0, 2'b01); tick();
        check("s6 first edge loaded EX", 32'(fwdSel), 32'h1);

        // Stall counter after repeating scenario 3 from a clean count
        setId(0, 0, 0, 0, 0, 0, 2'b00);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        setId(1, 5, 1, 1, 0, 0, 2'b00); tick();
        setId(1, 6, 1, 0, 5, 0, 2'b01); tick(); tick();
        check("s3b fwd from load at 2", 32'(fwdSel), 32'h2);
`ifdef FWD_STATS_EN
        check("s3b stall cnt", statStallCnt, 32'h1);
`endif

        setId(0, 0, 0, 0, 0, 0, 2'b00);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
